parser_rule_cfg: RTL and testbench
==================================

Name: parser_rule_cfg

Overview:
Configuration controller that loads, reads back and clears the per-layer type_rule_t rule tables of the pipelined parser. It accepts 32-bit command/data words from the host config stream and assembles 103-bit type_rule_t entries. It drives one write/read port per parser layer and returns read-back data on a response stream. It sits between the host config bus and the parser layers' rule RAMs.

Parameters:
LAYER_NUM, 4, number of parser layers (rule tables) addressed
RULE_NUM, 8, rules per layer (parser_pkg::RULE_NUM)
RULE_W, $bits(type_rule_t) = 103, derived from parser_pkg; do not override
ADDR_W, $clog2(RULE_NUM) = 3, derived

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_cfg_valid  in  1  config word valid
i_cfg_data  in  32  config word
o_cfg_ready  out  1  config word accepted when valid&ready
o_rule_wren  out  LAYER_NUM  one-hot write strobe per layer
o_rule_rden  out  LAYER_NUM  one-hot read strobe per layer
o_rule_addr  out  ADDR_W  rule index, shared by all layers
o_rule_wdata  out  RULE_W  type_rule_t write data
i_rule_rdata  in  LAYER_NUM*RULE_W  per-layer read data, valid 1 cycle after rden
o_resp_valid  out  1  read-back word valid
o_resp_data  out  32  read-back word
i_resp_ready  in  1  response consumer ready
o_busy  out  1  high in any state other than IDLE
o_err_cnt  out  16  saturating count of rejected commands

Behaviour:
- Header word: [31:28] opcode (1=WRITE, 2=READ, 3=CLEAR; others illegal), [27:24] layer, [23:16] rule, [15:0] ignored.
- Rule packing: type_rule_t packed, typeRule_valid at bit 102. Data word k carries bits [32k+31:32k], k=0..3, sent LSW first. In word3, only [6:0] are used; [31:7] are ignored on write and read back as 0.
- FSM states: IDLE, WDATA, WRITE, DRAIN, RD_REQ, RD_WAIT, RESP, CLEAR.
- IDLE: cfg_ready=1. On header accept:
  - WRITE with legal layer/rule -> WDATA (word cnt=0).
  - WRITE with illegal layer/rule -> DRAIN, err_cnt+1.
  - READ legal -> RD_REQ. READ illegal -> IDLE, err_cnt+1.
  - CLEAR legal layer -> CLEAR with addr=0. CLEAR illegal -> IDLE, err_cnt+1.
  - Illegal opcode -> IDLE, err_cnt+1.
  - Legal means layer<LAYER_NUM and rule<RULE_NUM; rule is not checked for CLEAR.
- WDATA: cfg_ready=1; assemble 4 words into a shadow register, then -> WRITE.
- WRITE: cfg_ready=0. One-cycle wren[layer]=1, addr=rule, wdata=shadow. The pulse occurs exactly 1 cycle after the 4th data word is accepted. Next state IDLE.
- DRAIN: cfg_ready=1; accept and discard 4 words; -> IDLE. No wren.
- RD_REQ: one-cycle rden[layer], addr=rule -> RD_WAIT. RD_WAIT: capture i_rule_rdata slice [layer] -> RESP.
- RESP: present words 0..3 in order. Each word holds until resp_valid&resp_ready, then advances. After word3 handshake -> IDLE. cfg_ready=0 throughout RD_*/RESP.
- CLEAR: wren[layer]=1, wdata=0, for addr 0..RULE_NUM-1 on consecutive cycles (RULE_NUM cycles), then -> IDLE. cfg_ready=0.
- Strobes are never asserted for more than one layer at a time. wren and rden are never asserted in the same cycle.
- err_cnt saturates at 16'hFFFF.
- Reset values: cfg_ready=0 during the reset cycle, then 1 in IDLE. wren, rden=0; addr=0; wdata=0; resp_valid=0; resp_data=0; busy=0; err_cnt=0.
- Reset mid-operation: in the cycle after i_rst deasserts, the FSM is in IDLE and any partial assembly is discarded. A WRITE interrupted before its strobe produces no write. A CLEAR interrupted by reset leaves later addresses untouched.
- resp_valid stays asserted with stable data while resp_ready=0 (no drop, no change).

Test Plan:
- WRITE layer2 rule5, data 0x11111111,0x22222222,0x33333333,0x0000007F -> exactly one wren=4'b0100, addr=5, wdata=103'h7F_33333333_22222222_11111111, 1 cycle after the last word.
- READ of the same entry with rdata 1 cycle after rden=4'b0100 -> resp words 0x11111111,0x22222222,0x33333333,0x0000007F. Hold resp_ready=0 for 3 cycles on word1 -> word1 held stable, no words lost.
- CLEAR layer1 -> wren=4'b0010 for 8 consecutive cycles, addr 0..7, wdata=0; cfg_ready=0 for those 8 cycles; then IDLE.
- WRITE layer=7 (illegal) + 4 data words -> all 4 words accepted, no wren, err_cnt=1. Opcode 0xF -> err_cnt=2. READ rule=9 -> err_cnt=3, no rden.
- Assert i_rst after 2 of 4 WRITE data words -> no wren, busy=0. A fresh WRITE afterward completes normally with only its own data.
- Force err_cnt to 0xFFFF via 65535 illegal headers, then one more -> err_cnt stays 0xFFFF.

Source files
------------

// File: rtl/parser_rule_cfg.sv
// Host-side configuration controller for the parser rule tables: assembles 103-bit
// rules from 32-bit config words and writes, reads back or clears one layer's table.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a header word
// S_WDATA   | collecting the four data words of a legal WRITE
// S_WRITE   | single write strobe of the assembled rule
// S_DRAIN   | swallowing the four data words of a rejected WRITE
// S_RD_REQ  | single read strobe to the addressed layer
// S_RD_WAIT | capturing the layer's read data
// S_RESP    | returning the captured rule as four response words
// S_CLEAR   | zeroing every rule of one layer, one address per cycle
module parser_rule_cfg #(
  parameter  int LAYER_NUM = 4,
  parameter  int RULE_NUM  = 8,
  localparam int RULE_W    = 103,
  localparam int ADDR_W    = $clog2(RULE_NUM)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cfg_valid,
  input  logic [31:0]                 i_cfg_data,
  output logic                        o_cfg_ready,
  output logic [LAYER_NUM-1:0]        o_rule_wren,
  output logic [LAYER_NUM-1:0]        o_rule_rden,
  output logic [ADDR_W-1:0]           o_rule_addr,
  output logic [RULE_W-1:0]           o_rule_wdata,
  input  logic [LAYER_NUM*RULE_W-1:0] i_rule_rdata,
  output logic                        o_resp_valid,
  output logic [31:0]                 o_resp_data,
  input  logic                        i_resp_ready,
  output logic                        o_busy,
  output logic [15:0]                 o_err_cnt
);

  localparam int LW = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;

  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;
  localparam logic [3:0] OP_CLEAR = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_WRITE, S_DRAIN, S_RD_REQ, S_RD_WAIT, S_RESP, S_CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [LW-1:0]       layer_q, layer_d;
  logic [ADDR_W-1:0]   rule_q, rule_d;
  logic [1:0]          word_q, word_d;
  logic [RULE_W-1:0]   shadow_q, shadow_d;
  logic [15:0]         err_q, err_d;

  logic [3:0]          hdr_op;
  logic [3:0]          hdr_layer;
  logic [7:0]          hdr_rule;
  logic                layer_ok;
  logic                rule_ok;
  logic                err_inc;
  logic [RULE_W-1:0]   rd_slice;
  logic [LAYER_NUM-1:0] layer_oh;

  logic                cfg_ready;
  logic                wren_sel;
  logic                rden_sel;
  logic [ADDR_W-1:0]   addr;
  logic [RULE_W-1:0]   wdata;
  logic                resp_valid;
  logic [31:0]         resp_data;

  assign hdr_op    = i_cfg_data[31:28];
  assign hdr_layer = i_cfg_data[27:24];
  assign hdr_rule  = i_cfg_data[23:16];
  assign layer_ok  = hdr_layer < 4'(LAYER_NUM);
  assign rule_ok   = hdr_rule < 8'(RULE_NUM);
  assign layer_oh  = {{(LAYER_NUM-1){1'b0}}, 1'b1} << layer_q;

  always_comb begin
    rd_slice = '0;
    for (int l = 0; l < LAYER_NUM; l++) begin
      if (layer_q == LW'(l)) rd_slice = i_rule_rdata[l*RULE_W +: RULE_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    rule_d     = rule_q;
    word_d     = word_q;
    shadow_d   = shadow_q;
    err_d      = err_q;
    err_inc    = 1'b0;
    cfg_ready  = 1'b0;
    wren_sel   = 1'b0;
    rden_sel   = 1'b0;
    addr       = '0;
    wdata      = '0;
    resp_valid = 1'b0;
    resp_data  = '0;

    case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (i_cfg_valid) begin
          layer_d = hdr_layer[LW-1:0];
          rule_d  = hdr_rule[ADDR_W-1:0];
          word_d  = '0;
          case (hdr_op)
            OP_WRITE: begin
              if (layer_ok && rule_ok) state_d = S_WDATA;
              else begin
                state_d = S_DRAIN;
                err_inc = 1'b1;
              end
            end
            OP_READ: begin
              if (layer_ok && rule_ok) state_d = S_RD_REQ;
              else                     err_inc = 1'b1;
            end
            OP_CLEAR: begin
              if (layer_ok) begin
                state_d = S_CLEAR;
                rule_d  = '0;
              end else begin
                err_inc = 1'b1;
              end
            end
            default: err_inc = 1'b1;
          endcase
        end
      end
      S_WDATA: begin
        cfg_ready = 1'b1;
        if (i_cfg_valid) begin
          case (word_q)
            2'd0: shadow_d[31:0]  = i_cfg_data;
            2'd1: shadow_d[63:32] = i_cfg_data;
            2'd2: shadow_d[95:64] = i_cfg_data;
            default: shadow_d[RULE_W-1:96] = i_cfg_data[RULE_W-97:0];
          endcase
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wren_sel = 1'b1;
        addr     = rule_q;
        wdata    = shadow_q;
        state_d  = S_IDLE;
      end
      S_DRAIN: begin
        cfg_ready = 1'b1;
        if (i_cfg_valid) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        rden_sel = 1'b1;
        addr     = rule_q;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        shadow_d = rd_slice;
        word_d   = '0;
        state_d  = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        case (word_q)
          2'd0: resp_data = shadow_q[31:0];
          2'd1: resp_data = shadow_q[63:32];
          2'd2: resp_data = shadow_q[95:64];
          default: resp_data = {{(128-RULE_W){1'b0}}, shadow_q[RULE_W-1:96]};
        endcase
        if (i_resp_ready) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        wren_sel = 1'b1;
        addr     = rule_q;
        rule_d   = rule_q + 1'b1;
        if (rule_q == ADDR_W'(RULE_NUM-1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (err_inc && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      layer_q  <= '0;
      rule_q   <= '0;
      word_q   <= '0;
      shadow_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      rule_q   <= rule_d;
      word_q   <= word_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  // Everything is held quiet while reset is asserted so an interrupted CLEAR
  // cannot touch the address that was in flight.
  assign o_cfg_ready  = cfg_ready & ~i_rst;
  assign o_rule_wren  = (wren_sel & ~i_rst) ? layer_oh : '0;
  assign o_rule_rden  = (rden_sel & ~i_rst) ? layer_oh : '0;
  assign o_rule_addr  = i_rst ? '0 : addr;
  assign o_rule_wdata = i_rst ? '0 : wdata;
  assign o_resp_valid = resp_valid & ~i_rst;
  assign o_resp_data  = i_rst ? '0 : resp_data;
  assign o_busy       = (state_q != S_IDLE) & ~i_rst;
  assign o_err_cnt    = err_q;

endmodule

// File: tb/tb_parser_rule_cfg.sv
// Directed bench for parser_rule_cfg with a small behavioural rule-RAM per layer.
`timescale 1ns/1ps
module tb_parser_rule_cfg;
  localparam int LAYER_NUM = 4;
  localparam int RULE_NUM  = 8;
  localparam int RULE_W    = 103;
  localparam int ADDR_W    = 3;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        cfg_valid;
  logic [31:0]                 cfg_data;
  logic                        cfg_ready;
  logic [LAYER_NUM-1:0]        wren, rden;
  logic [ADDR_W-1:0]           addr;
  logic [RULE_W-1:0]           wdata;
  logic [LAYER_NUM*RULE_W-1:0] rdata;
  logic                        resp_valid;
  logic [31:0]                 resp_data;
  logic                        resp_ready;
  logic                        busy;
  logic [15:0]                 err_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_err  = 0;
  int wr_pulses = 0, rd_pulses = 0, both_hi = 0, multi_hot = 0;

  always #5 clk = ~clk;

  parser_rule_cfg #(.LAYER_NUM(LAYER_NUM), .RULE_NUM(RULE_NUM)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .i_cfg_data(cfg_data),
    .o_cfg_ready(cfg_ready), .o_rule_wren(wren), .o_rule_rden(rden),
    .o_rule_addr(addr), .o_rule_wdata(wdata), .i_rule_rdata(rdata),
    .o_resp_valid(resp_valid), .o_resp_data(resp_data), .i_resp_ready(resp_ready),
    .o_busy(busy), .o_err_cnt(err_cnt)
  );

  // Rule RAM model: one-cycle read latency, preloaded with a per-entry pattern.
  logic [RULE_W-1:0] mem  [LAYER_NUM][RULE_NUM];
  logic [RULE_W-1:0] rd_r [LAYER_NUM];
  bit mem_loaded = 1'b0;

  function automatic logic [RULE_W-1:0] init_pat(int l, int r);
    return {7'h40 | 7'(r), 32'hC0DE_0000 + 32'(l*256 + r), 32'h5A5A_0000 + 32'(l),
            32'hA5A5_0000 + 32'(r)};
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int l = 0; l < LAYER_NUM; l++)
        for (int r = 0; r < RULE_NUM; r++) mem[l][r] <= init_pat(l, r);
      mem_loaded <= 1'b1;
    end else begin
      for (int l = 0; l < LAYER_NUM; l++) begin
        if (wren[l]) mem[l][addr] <= wdata;
        if (rden[l]) rd_r[l] <= mem[l][addr];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int l = 0; l < LAYER_NUM; l++) rdata[l*RULE_W +: RULE_W] = rd_r[l];
  end

  always @(negedge clk) begin
    if (wren != 0) wr_pulses++;
    if (rden != 0) rd_pulses++;
    if (wren != 0 && rden != 0) both_hi++;
    if (!$onehot0(wren) || !$onehot0(rden)) multi_hot++;
  end

  // Offers one config word and waits (bounded) until it is accepted.
  task automatic send_word(input logic [31:0] d);
    bit ok = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    for (int i = 0; i < 20; i++) begin
      if (cfg_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL cfg_accept: word %h not accepted within 20 cycles", d); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; resp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_assert++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_ready: got %b want 0", cfg_ready); end
    n_assert++; if (wren !== 4'b0 || rden !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got wren %b rden %b want 0", wren, rden); end
    n_assert++; if (addr !== 3'd0 || wdata !== '0) begin n_fail++; $display("FAIL rst_addr_wdata: got %h/%h want 0", addr, wdata); end
    n_assert++; if (resp_valid !== 1'b0 || resp_data !== 32'd0) begin n_fail++; $display("FAIL rst_resp: got %b/%h want 0", resp_valid, resp_data); end
    n_assert++; if (busy !== 1'b0 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_busy_err: got %b/%h want 0/0", busy, err_cnt); end
    rst = 1'b0; #1;
    n_assert++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got ready %b busy %b want 1/0", cfg_ready, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int w0 = wr_pulses;
    send_word({4'h1, 4'h2, 8'h05, 16'hBEEF});
    n_assert++; if (busy !== 1'b1 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL wr_wdata_state: got busy %b ready %b want 1/1", busy, cfg_ready); end
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_word(32'h0000_007F);
    n_assert++; if (wren !== 4'b0100) begin n_fail++; $display("FAIL wr_wren: got %b want 0100", wren); end
    n_assert++; if (addr !== 3'd5) begin n_fail++; $display("FAIL wr_addr: got %0d want 5", addr); end
    n_assert++; if (wdata !== 103'h7F_33333333_22222222_11111111) begin n_fail++; $display("FAIL wr_wdata: got %h want 7f333333332222222211111111", wdata); end
    n_assert++; if (cfg_ready !== 1'b0 || rden !== 4'b0) begin n_fail++; $display("FAIL wr_ready_rden: got %b/%b want 0/0000", cfg_ready, rden); end
    @(posedge clk); #1;
    n_assert++; if (wren !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_after: got wren %b busy %b want 0/0", wren, busy); end
    n_assert++; if (wr_pulses - w0 != 1) begin n_fail++; $display("FAIL wr_pulse_count: got %0d want 1", wr_pulses - w0); end
  endtask

  task automatic test_read_backpressure();
    int r0 = rd_pulses;
    bit seen = 1'b0;
    send_word({4'h2, 4'h2, 8'h05, 16'h0});
    n_assert++; if (rden !== 4'b0100 || addr !== 3'd5 || wren !== 4'b0) begin n_fail++; $display("FAIL rd_req: got rden %b addr %0d wren %b want 0100/5/0000", rden, addr, wren); end
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_assert++; if (!seen) begin n_fail++; $display("FAIL rd_resp_timeout: resp_valid never rose within 10 cycles"); end
    n_assert++; if (resp_data !== 32'h1111_1111) begin n_fail++; $display("FAIL rd_word0: got %h want 11111111", resp_data); end
    resp_ready = 1'b1; @(posedge clk); #1; resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_assert++; if (resp_valid !== 1'b1 || resp_data !== 32'h2222_2222) begin n_fail++; $display("FAIL rd_word1_hold%0d: got %b/%h want 1/22222222", i, resp_valid, resp_data); end
      if (i < 3) begin @(posedge clk); #1; end
    end
    resp_ready = 1'b1; @(posedge clk); #1;
    n_assert++; if (resp_valid !== 1'b1 || resp_data !== 32'h3333_3333) begin n_fail++; $display("FAIL rd_word2: got %b/%h want 1/33333333", resp_valid, resp_data); end
    @(posedge clk); #1;
    n_assert++; if (resp_valid !== 1'b1 || resp_data !== 32'h0000_007F) begin n_fail++; $display("FAIL rd_word3: got %b/%h want 1/0000007f", resp_valid, resp_data); end
    @(posedge clk); #1; resp_ready = 1'b0;
    n_assert++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_done: got valid %b busy %b want 0/0", resp_valid, busy); end
    n_assert++; if (rd_pulses - r0 != 1) begin n_fail++; $display("FAIL rd_pulse_count: got %0d want 1", rd_pulses - r0); end
  endtask

  task automatic test_clear();
    send_word({4'h3, 4'h1, 8'hFF, 16'h0});
    for (int i = 0; i < RULE_NUM; i++) begin
      n_assert++;
      if (wren !== 4'b0010 || addr !== 3'(i) || wdata !== '0 || cfg_ready !== 1'b0) begin
        n_fail++; $display("FAIL clr_cycle%0d: got wren %b addr %0d wdata %h ready %b want 0010/%0d/0/0", i, wren, addr, wdata, cfg_ready, i);
      end
      @(posedge clk); #1;
    end
    n_assert++; if (wren !== 4'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_done: got wren %b ready %b busy %b want 0000/1/0", wren, cfg_ready, busy); end
    n_assert++; if (err_cnt !== 16'(exp_err)) begin n_fail++; $display("FAIL clr_no_err: got %0d want %0d", err_cnt, exp_err); end
    n_assert++; if (mem[1][7] !== '0 || mem[1][0] !== '0) begin n_fail++; $display("FAIL clr_mem: got %h/%h want 0/0", mem[1][0], mem[1][7]); end
  endtask

  task automatic test_errors();
    int w0 = wr_pulses;
    int r0;
    send_word({4'h1, 4'h7, 8'h00, 16'h0});
    exp_err = 1;
    n_assert++; if (err_cnt !== 16'(exp_err) || busy !== 1'b1 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL err_wr_layer: got err %0d busy %b ready %b want 1/1/1", err_cnt, busy, cfg_ready); end
    send_word(32'hAAAA_0001);
    send_word(32'hAAAA_0002);
    send_word(32'hAAAA_0003);
    send_word(32'hAAAA_0004);
    n_assert++; if (busy !== 1'b0 || wren !== 4'b0) begin n_fail++; $display("FAIL err_drain_done: got busy %b wren %b want 0/0000", busy, wren); end
    @(posedge clk); #1;
    n_assert++; if (wr_pulses != w0) begin n_fail++; $display("FAIL err_drain_nowrite: got %0d pulses want 0", wr_pulses - w0); end
    send_word({4'hF, 4'h0, 8'h00, 16'h0});
    exp_err = 2;
    n_assert++; if (err_cnt !== 16'(exp_err) || busy !== 1'b0) begin n_fail++; $display("FAIL err_opcode: got err %0d busy %b want 2/0", err_cnt, busy); end
    r0 = rd_pulses;
    send_word({4'h2, 4'h0, 8'h09, 16'h0});
    exp_err = 3;
    n_assert++; if (err_cnt !== 16'(exp_err) || rden !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_rd_rule: got err %0d rden %b busy %b want 3/0000/0", err_cnt, rden, busy); end
    @(posedge clk); #1;
    n_assert++; if (rd_pulses != r0) begin n_fail++; $display("FAIL err_rd_norden: got %0d pulses want 0", rd_pulses - r0); end
    send_word({4'h3, 4'h4, 8'h00, 16'h0});
    exp_err = 4;
    n_assert++; if (err_cnt !== 16'(exp_err) || wren !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL err_clr_layer: got err %0d wren %b busy %b want 4/0000/0", err_cnt, wren, busy); end
    send_word({4'h0, 4'h0, 8'h00, 16'h0});
    exp_err = 5;
    n_assert++; if (err_cnt !== 16'(exp_err)) begin n_fail++; $display("FAIL err_opcode0: got %0d want 5", err_cnt); end
  endtask

  task automatic test_reset_mid_op();
    int w0 = wr_pulses;
    send_word({4'h1, 4'h3, 8'h01, 16'h0});
    send_word(32'h5555_5555);
    send_word(32'h6666_6666);
    rst = 1'b1;
    @(posedge clk); #1;
    n_assert++; if (wren !== 4'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_reset: got wren %b busy %b ready %b want 0000/0/0", wren, busy, cfg_ready); end
    rst = 1'b0; #1;
    exp_err = 0;
    n_assert++; if (busy !== 1'b0 || cfg_ready !== 1'b1 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_idle: got busy %b ready %b err %0d want 0/1/0", busy, cfg_ready, err_cnt); end
    @(posedge clk); #1;
    n_assert++; if (wr_pulses != w0) begin n_fail++; $display("FAIL rmid_nowrite: got %0d pulses want 0", wr_pulses - w0); end
    send_word({4'h1, 4'h3, 8'h01, 16'h0});
    send_word(32'hCAFE_F00D);
    send_word(32'h1234_5678);
    send_word(32'h9ABC_DEF0);
    send_word(32'hFFFF_FF85);
    n_assert++; if (wren !== 4'b1000 || addr !== 3'd1 || wdata !== 103'h05_9ABCDEF0_12345678_CAFEF00D) begin n_fail++; $display("FAIL rmid_fresh_write: got wren %b addr %0d wdata %h want 1000/1/059abcdef012345678cafef00d", wren, addr, wdata); end
    @(posedge clk); #1;
    n_assert++; if (wr_pulses - w0 != 1) begin n_fail++; $display("FAIL rmid_fresh_count: got %0d want 1", wr_pulses - w0); end
    // Interrupt a CLEAR of layer 0 after addresses 0 and 1 have been written.
    send_word({4'h3, 4'h0, 8'h00, 16'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    n_assert++; if (busy !== 1'b0 || wren !== 4'b0) begin n_fail++; $display("FAIL rclr_idle: got busy %b wren %b want 0/0000", busy, wren); end
    @(posedge clk); #1;
    n_assert++; if (mem[0][1] !== '0) begin n_fail++; $display("FAIL rclr_done_addr: got %h want 0", mem[0][1]); end
    n_assert++; if (mem[0][4] !== init_pat(0, 4) || mem[0][7] !== init_pat(0, 7)) begin n_fail++; $display("FAIL rclr_untouched: got %h/%h want %h/%h", mem[0][4], mem[0][7], init_pat(0, 4), init_pat(0, 7)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    int k;
    exp_a[0] = 32'hDEAD_BEEF; exp_a[1] = 32'h0BAD_F00D; exp_a[2] = 32'h0123_4567; exp_a[3] = 32'h0000_0001;
    exp_b[0] = 32'hA5A5_0006; exp_b[1] = 32'h5A5A_0003; exp_b[2] = 32'hC0DE_0306; exp_b[3] = 32'h0000_0046;
    send_word({4'h1, 4'h0, 8'h07, 16'h0});
    send_word(32'hDEAD_BEEF);
    send_word(32'h0BAD_F00D);
    send_word(32'h0123_4567);
    send_word(32'hABCD_EF81);
    send_word({4'h2, 4'h0, 8'h07, 16'h0});
    resp_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      if (resp_valid) begin
        n_assert++; if (resp_data !== exp_a[k]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", k, resp_data, exp_a[k]); end
        k++;
      end
      @(posedge clk); #1;
    end
    n_assert++; if (k != 4) begin n_fail++; $display("FAIL b2b_count: got %0d words want 4", k); end
    send_word({4'h2, 4'h3, 8'h06, 16'h0});
    k = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      if (resp_valid) begin
        n_assert++; if (resp_data !== exp_b[k]) begin n_fail++; $display("FAIL lsel_word%0d: got %h want %h", k, resp_data, exp_b[k]); end
        k++;
      end
      @(posedge clk); #1;
    end
    n_assert++; if (k != 4) begin n_fail++; $display("FAIL lsel_count: got %0d words want 4", k); end
    resp_ready = 1'b0;
  endtask

  task automatic test_strobe_rules();
    n_assert++; if (both_hi != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles want 0", both_hi); end
    n_assert++; if (multi_hot != 0) begin n_fail++; $display("FAIL strobe_onehot: got %0d cycles want 0", multi_hot); end
  endtask

  task automatic test_err_saturate();
    int n = 65534 - exp_err;
    cfg_valid = 1'b1;
    cfg_data  = 32'hF000_0000;
    repeat (n) @(posedge clk);
    #1;
    n_assert++; if (err_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe: got %h want fffe", err_cnt); end
    @(posedge clk); #1;
    n_assert++; if (err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff: got %h want ffff", err_cnt); end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    n_assert++; if (err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_backpressure();
    test_clear();
    test_errors();
    test_reset_mid_op();
    test_back_to_back();
    test_strobe_rules();
    test_err_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded 3 ms");
    $fatal(1);
  end

endmodule
